// File: rtl/act_arbiter.sv
// Round-robin arbiter sharing one fixed-latency activation unit between two requesters.
// Each issued operation carries a requester tag down a LAT-deep pipeline so its result is routed back.
module act_arbiter #(
   parameter int LAT = 4,
   parameter int W   = 32
) (
   input  logic         CLOCK_50,
   input  logic         reset_n,
   input  logic         enable,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_x,
   input  logic         req0_mode,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_x,
   input  logic         req1_mode,
   output logic         unit_valid,
   output logic [W-1:0] unit_x,
   output logic         unit_mode,
   input  logic [W-1:0] unit_y,
   output logic         rsp0_valid,
   output logic [W-1:0] rsp0_y,
   output logic         rsp1_valid,
   output logic [W-1:0] rsp1_y,
   output logic         busy,
   output logic [15:0]  done_cnt
);

   logic           prio_q, prio_d;
   logic           grant0, grant1;
   logic           unit_valid_q, unit_mode_q, issue_id_q;
   logic [W-1:0]   unit_x_q;
   logic [LAT-1:0] tag_v_q, tag_id_q;
   logic           rsp0_valid_q, rsp1_valid_q;
   logic [W-1:0]   rsp0_y_q, rsp1_y_q;
   logic [15:0]    done_cnt_q, done_cnt_d;
   logic           tag_out_v, tag_out_id;

   assign tag_out_v  = tag_v_q[LAT-1];
   assign tag_out_id = tag_id_q[LAT-1];

   always_comb begin
      grant0     = enable & req0_valid & (~req1_valid | ~prio_q);
      grant1     = enable & req1_valid & (~req0_valid |  prio_q);
      prio_d     = prio_q;
      if (grant0) begin
         prio_d = 1'b1;
      end else if (grant1) begin
         prio_d = 1'b0;
      end
      done_cnt_d = done_cnt_q + (tag_out_v ? 16'd1 : 16'd0);
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         prio_q       <= 1'b0;
         unit_valid_q <= 1'b0;
         unit_mode_q  <= 1'b0;
         unit_x_q     <= '0;
         issue_id_q   <= 1'b0;
         tag_v_q      <= '0;
         tag_id_q     <= '0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_y_q     <= '0;
         rsp1_y_q     <= '0;
         done_cnt_q   <= '0;
      end else begin
         prio_q       <= prio_d;
         unit_valid_q <= grant0 | grant1;
         if (grant0) begin
            unit_x_q    <= req0_x;
            unit_mode_q <= req0_mode;
            issue_id_q  <= 1'b0;
         end else if (grant1) begin
            unit_x_q    <= req1_x;
            unit_mode_q <= req1_mode;
            issue_id_q  <= 1'b1;
         end
         // Tag stage LAT-1 coincides with the cycle unit_y carries that operation's result.
         tag_v_q[0]  <= unit_valid_q;
         tag_id_q[0] <= issue_id_q;
         for (int i = 1; i < LAT; i++) begin
            tag_v_q[i]  <= tag_v_q[i-1];
            tag_id_q[i] <= tag_id_q[i-1];
         end
         rsp0_valid_q <= tag_out_v & ~tag_out_id;
         rsp1_valid_q <= tag_out_v &  tag_out_id;
         if (tag_out_v & ~tag_out_id) rsp0_y_q <= unit_y;
         if (tag_out_v &  tag_out_id) rsp1_y_q <= unit_y;
         done_cnt_q <= done_cnt_d;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign unit_valid = unit_valid_q;
   assign unit_x     = unit_x_q;
   assign unit_mode  = unit_mode_q;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp0_y     = rsp0_y_q;
   assign rsp1_y     = rsp1_y_q;
   assign busy       = unit_valid_q | (|tag_v_q);
   assign done_cnt   = done_cnt_q;

endmodule

// File: tb/tb_act_arbiter.sv
// Bench for act_arbiter: queue-based reference model checked every cycle, plus directed scenarios
// with hand-computed expectations. The activation unit is modelled as x ^ {mode, 31'b0} after LAT cycles.
module tb_act_arbiter;
   localparam int LAT = 4;
   localparam int W   = 32;

   logic          CLOCK_50 = 1'b0;
   logic          reset_n  = 1'b0;
   logic          enable   = 1'b1;
   logic          req0_valid = 1'b0, req0_mode = 1'b0;
   logic          req1_valid = 1'b0, req1_mode = 1'b0;
   logic [W-1:0]  req0_x = '0, req1_x = '0;
   logic [W-1:0]  unit_y = '0;
   logic          req0_ready, req1_ready, unit_valid, unit_mode;
   logic          rsp0_valid, rsp1_valid, busy;
   logic [W-1:0]  unit_x, rsp0_y, rsp1_y;
   logic [15:0]   done_cnt;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_hs  = 0;
   int glog[$];

   act_arbiter #(.LAT(LAT), .W(W)) dut (
      .CLOCK_50(CLOCK_50), .reset_n(reset_n), .enable(enable),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_mode(req0_mode),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_mode(req1_mode),
      .unit_valid(unit_valid), .unit_x(unit_x), .unit_mode(unit_mode), .unit_y(unit_y),
      .rsp0_valid(rsp0_valid), .rsp0_y(rsp0_y), .rsp1_valid(rsp1_valid), .rsp1_y(rsp1_y),
      .busy(busy), .done_cnt(done_cnt)
   );

   always #5 CLOCK_50 = ~CLOCK_50;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
      end
   endfunction

   // Activation unit stand-in
   logic [31:0] ring [16];
   initial for (int i = 0; i < 16; i++) ring[i] = '0;
   always @(negedge CLOCK_50) begin
      if (unit_valid) ring[4'((cyc + LAT) % 16)] = unit_x ^ {unit_mode, 31'b0};
      unit_y = ring[4'(cyc % 16)];
   end

   // Reference model: pending responses with their due cycle
   typedef struct {
      int          due;
      bit          id;
      logic [31:0] y;
   } rsp_t;
   rsp_t        mq[$];
   logic        m_prio = 1'b0, m_uv = 1'b0, m_um = 1'b0;
   logic [31:0] m_ux = '0, m_y0 = '0, m_y1 = '0;
   logic [15:0] m_done = '0;

   always @(negedge CLOCK_50) begin
      logic e0, e1, ev0, ev1;
      if (!reset_n) begin
         mq.delete();
         m_prio = 1'b0; m_uv = 1'b0; m_um = 1'b0;
         m_ux = '0; m_y0 = '0; m_y1 = '0; m_done = '0;
         chk("rst unit_valid", unit_valid, 0);
         chk("rst unit_x", unit_x, 0);
         chk("rst rsp0_valid", rsp0_valid, 0);
         chk("rst rsp1_valid", rsp1_valid, 0);
         chk("rst rsp0_y", rsp0_y, 0);
         chk("rst rsp1_y", rsp1_y, 0);
         chk("rst busy", busy, 0);
         chk("rst done_cnt", done_cnt, 0);
      end else begin
         chk("unit_valid", unit_valid, m_uv);
         chk("unit_x", unit_x, m_ux);
         chk("unit_mode", unit_mode, m_um);
         ev0 = 1'b0; ev1 = 1'b0;
         if (mq.size() > 0 && mq[0].due == cyc) begin
            if (mq[0].id) begin ev1 = 1'b1; m_y1 = mq[0].y; end
            else          begin ev0 = 1'b1; m_y0 = mq[0].y; end
            m_done++;
            void'(mq.pop_front());
         end
         chk("rsp0_valid", rsp0_valid, ev0);
         chk("rsp1_valid", rsp1_valid, ev1);
         chk("rsp0_y", rsp0_y, m_y0);
         chk("rsp1_y", rsp1_y, m_y1);
         chk("done_cnt", done_cnt, m_done);
         chk("busy", busy, mq.size() > 0);
         e0 = enable && req0_valid && (!req1_valid || !m_prio);
         e1 = enable && req1_valid && (!req0_valid ||  m_prio);
         chk("req0_ready", req0_ready, e0);
         chk("req1_ready", req1_ready, e1);
         m_uv = 1'b0;
         if (e0 || e1) begin
            m_uv = 1'b1;
            m_ux = e0 ? req0_x : req1_x;
            m_um = e0 ? req0_mode : req1_mode;
            mq.push_back('{cyc + LAT + 2, e1, m_ux ^ {m_um, 31'b0}});
            m_prio = e0;
         end
      end
   end

   task automatic step();
      @(posedge CLOCK_50); #1;
   endtask

   task automatic at_cycle(input int c);
      do @(negedge CLOCK_50); while (cyc < c);
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge CLOCK_50);
      #1 reset_n = 1'b1;
   endtask

   // Presents n0/n1 operands (x incrementing per transfer); called and returns at posedge+1.
   task automatic drive(input int n0, input int n1, input int max_cyc);
      int left0 = n0, left1 = n1, k = 0;
      bit h0, h1;
      while ((left0 > 0 || left1 > 0) && k < max_cyc) begin
         req0_valid = (left0 > 0);
         req1_valid = (left1 > 0);
         @(negedge CLOCK_50);
         h0 = req0_valid && req0_ready;
         h1 = req1_valid && req1_ready;
         if (h0) begin left0--; glog.push_back(0); last_hs = cyc; end
         if (h1) begin left1--; glog.push_back(1); last_hs = cyc; end
         step();
         if (h0) req0_x = req0_x + 1;
         if (h1) req1_x = req1_x + 1;
         k++;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("drive timeout", (left0 > 0 || left1 > 0), 0);
   endtask

   initial begin
      int n, k, rdy, pulses;
      logic [15:0] seen [3];
      repeat (3) @(posedge CLOCK_50);
      #1 reset_n = 1'b1;
      step();

      // 1: single transfer, latency and busy window
      req0_x = 32'h3F80_0000; req0_mode = 1'b0;
      drive(1, 0, 10);
      at_cycle(last_hs + 1);
      chk("t1 unit_valid", unit_valid, 1);
      chk("t1 unit_x", unit_x, 32'h3F80_0000);
      at_cycle(last_hs + 5);
      chk("t1 busy before rsp", busy, 1);
      chk("t1 rsp0 early", rsp0_valid, 0);
      at_cycle(last_hs + 6);
      chk("t1 rsp0_valid", rsp0_valid, 1);
      chk("t1 rsp0_y", rsp0_y, 32'h3F80_0000);
      chk("t1 rsp1_valid", rsp1_valid, 0);
      chk("t1 done_cnt", done_cnt, 1);
      chk("t1 busy after", busy, 0);
      step();

      // 2: both valid from reset, alternating grants
      pulse_reset();
      req0_x = 32'd100; req0_mode = 1'b0;
      req1_x = 32'd200; req1_mode = 1'b1;
      glog.delete();
      drive(3, 3, 20);
      chk("t2 grant count", glog.size(), 6);
      for (int i = 0; i < 6; i++) chk("t2 grant order", (i < glog.size()) ? glog[i] : -1, i % 2);
      repeat (LAT + 4) step();
      chk("t2 done_cnt", done_cnt, 6);
      chk("t2 rsp0_y last", rsp0_y, 32'h0000_0066);
      chk("t2 rsp1_y last", rsp1_y, 32'h8000_00CA);

      // 3: req1 streaming alone, one grant per cycle
      req1_x = 32'd1; req1_mode = 1'b0;
      glog.delete();
      drive(0, 8, 8);
      chk("t3 grant count", glog.size(), 8);
      repeat (LAT + 4) step();
      chk("t3 rsp1_y last", rsp1_y, 32'd8);
      chk("t3 done_cnt", done_cnt, 14);

      // 4: enable drop with both requesters still valid
      req0_x = 32'h10; req1_x = 32'h20;
      glog.delete();
      req0_valid = 1'b1; req1_valid = 1'b1;
      n = 0; k = 0;
      while (n < 3 && k < 10) begin
         bit h0, h1;
         @(negedge CLOCK_50);
         h0 = req0_ready; h1 = req1_ready;
         if (h0) begin n++; glog.push_back(0); end
         if (h1) begin n++; glog.push_back(1); end
         step();
         if (h0) req0_x = req0_x + 1;
         if (h1) req1_x = req1_x + 1;
         k++;
      end
      enable = 1'b0;
      chk("t4 transfers", n, 3);
      chk("t4 grant0", glog.size() > 0 ? glog[0] : -1, 0);
      chk("t4 grant1", glog.size() > 1 ? glog[1] : -1, 1);
      chk("t4 grant2", glog.size() > 2 ? glog[2] : -1, 0);
      rdy = 0; pulses = 0;
      repeat (10) begin
         @(negedge CLOCK_50);
         rdy    += int'(req0_ready) + int'(req1_ready);
         pulses += int'(rsp0_valid) + int'(rsp1_valid);
      end
      chk("t4 readies disabled", rdy, 0);
      chk("t4 inflight rsps", pulses, 3);
      chk("t4 busy idle", busy, 0);
      chk("t4 done_cnt", done_cnt, 17);
      step();
      enable = 1'b1;
      @(negedge CLOCK_50);
      chk("t4 resume ready1", req1_ready, 1);
      chk("t4 resume ready0", req0_ready, 0);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (LAT + 4) step();

      // 5: reset with three operations in flight
      req0_x = 32'h40; req1_x = 32'h50;
      drive(2, 1, 10);
      reset_n = 1'b0;
      #1;
      chk("t5 unit_valid now", unit_valid, 0);
      chk("t5 busy now", busy, 0);
      chk("t5 done_cnt now", done_cnt, 0);
      chk("t5 rsp0_y now", rsp0_y, 0);
      repeat (2) @(posedge CLOCK_50);
      #1 reset_n = 1'b1;
      pulses = 0;
      repeat (10) begin
         @(negedge CLOCK_50);
         pulses += int'(rsp0_valid) + int'(rsp1_valid);
      end
      chk("t5 no rsp after reset", pulses, 0);
      chk("t5 done_cnt", done_cnt, 0);
      step();
      glog.delete();
      drive(1, 1, 5);
      chk("t5 first grant", glog.size() > 0 ? glog[0] : -1, 0);
      repeat (LAT + 4) step();

      // 6: done_cnt wrap
      pulse_reset();
      req1_x = '0; req1_mode = 1'b0;
      drive(0, 65534, 70000);
      repeat (LAT + 4) step();
      chk("t6 preload", done_cnt, 16'hFFFE);
      drive(0, 3, 5);
      n = 0;
      for (int i = 0; i < 3; i++) seen[i] = 16'hDEAD;
      repeat (LAT + 6) begin
         @(negedge CLOCK_50);
         if (rsp1_valid) begin
            if (n < 3) seen[n] = done_cnt;
            n++;
         end
      end
      chk("t6 pulses", n, 3);
      chk("t6 cnt0", seen[0], 16'hFFFF);
      chk("t6 cnt1", seen[1], 16'h0000);
      chk("t6 cnt2", seen[2], 16'h0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
